// File: rtl/mig_port_pkg.sv
// Shared definitions for the MIG AXI master front-end.
//   - state_t      : command FSM states
//   - RESP_*       : AXI response codes
//   - BURST_INCR   : AXI INCR burst type
//   - BOUNDARY_4K  : bursts must not cross this byte boundary
//   - log2_bytes() : log2 of bytes per data beat (AXI size field)
package mig_port_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam int BOUNDARY_4K = 4096;

  function automatic int log2_bytes(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mig_burst_calc.sv
// Burst planner. When load is pulsed it registers the burst to issue at
// addr_in: its start address, AXI len, and the address / remaining beats
// that follow it. Burst size is min(rem_in, MAX_BURST, beats to next 4 KB).
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   load             : capture a new (addr_in, rem_in) pair
//   addr_in, rem_in  : beat-aligned start address, beats still to move
//   bst_addr/bst_len : current burst address and len (beats-1)
//   nxt_addr/nxt_rem : address and remaining beats after this burst
module mig_burst_calc
  import mig_port_pkg::*;
#(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 256,
  parameter int MAX_BURST = 16,
  parameter int BEATS_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic [BEATS_W-1:0] rem_in,
  output logic [ADDR_W-1:0]  bst_addr,
  output logic [7:0]         bst_len,
  output logic [ADDR_W-1:0]  nxt_addr,
  output logic [BEATS_W-1:0] nxt_rem
);

  localparam int LB = log2_bytes(DATA_W);

  logic [12:0] to_bnd;
  logic [31:0] n;

  always_comb begin
    // Beats left in the current 4 KB page; 13 bits so a page-aligned
    // address yields the full page count.
    to_bnd = (13'(BOUNDARY_4K) - {1'b0, addr_in[11:0]}) >> LB;
    n = 32'(MAX_BURST);
    if ({19'd0, to_bnd} < n) n = {19'd0, to_bnd};
    if (32'(rem_in) < n)     n = 32'(rem_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bst_addr <= '0;
      bst_len  <= '0;
      nxt_addr <= '0;
      nxt_rem  <= '0;
    end else if (load) begin
      bst_addr <= addr_in;
      bst_len  <= (n == 32'd0) ? 8'd0 : 8'(n - 32'd1);
      nxt_addr <= addr_in + ADDR_W'(n << LB);  // wraps modulo 2^ADDR_W
      nxt_rem  <= rem_in - BEATS_W'(n);
    end
  end

endmodule

// File: rtl/mig_axi_port.sv
// AXI4 master front-end for the MIG AXI slave port. Splits user commands
// (address, beat count, direction) into INCR bursts capped at MAX_BURST
// and never crossing 4 KB, one burst outstanding at a time.
// Ports:
//   ui_clk, ui_clk_sync_rst   : clock, synchronous active-high reset
//   init_calib_complete       : gates acceptance of new commands
//   cmd_*                     : command handshake, address, beats, direction
//   wr_*                      : user write data (passes through to W)
//   rd_*                      : user read data (passes through from R)
//   cmd_done / cmd_err        : completion pulse and sticky response error
//   err_count                 : non-OKAY response counter
//   m_axi_*                   : AXI4 master AW/W/B/AR/R channels
// Build option: define MIG_PORT_ERR_CNT_EN to implement err_count as a
// saturating count of non-OKAY B responses and R beats; otherwise it is 0.
module mig_axi_port
  import mig_port_pkg::*;
#(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 256,
  parameter int ID_W      = 4,
  parameter int AXI_ID    = 0,
  parameter int MAX_BURST = 16,
  parameter int BEATS_W   = 16
) (
  input  logic                ui_clk,
  input  logic                ui_clk_sync_rst,
  input  logic                init_calib_complete,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [BEATS_W-1:0]  cmd_beats,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                cmd_done,
  output logic                cmd_err,
  output logic [15:0]         err_count,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  localparam int LB = log2_bytes(DATA_W);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << LB) - 1);

  state_t state, state_nx;
  logic   is_write, err_sticky;
  logic [7:0] beat_cnt;

  logic               calc_load;
  logic [ADDR_W-1:0]  calc_addr;
  logic [BEATS_W-1:0] calc_rem;
  logic [ADDR_W-1:0]  bst_addr, nxt_addr;
  logic [7:0]         bst_len;
  logic [BEATS_W-1:0] nxt_rem;
  logic               bad_resp;

  // Response IDs are not used: one burst is outstanding with a fixed ID.
  logic unused_ids;
  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  mig_burst_calc #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .BEATS_W(BEATS_W)
  ) u_calc (
    .clk(ui_clk), .rst(ui_clk_sync_rst), .load(calc_load),
    .addr_in(calc_addr), .rem_in(calc_rem),
    .bst_addr(bst_addr), .bst_len(bst_len),
    .nxt_addr(nxt_addr), .nxt_rem(nxt_rem)
  );

  assign m_axi_awid    = ID_W'(AXI_ID);
  assign m_axi_arid    = ID_W'(AXI_ID);
  assign m_axi_awaddr  = bst_addr;
  assign m_axi_araddr  = bst_addr;
  assign m_axi_awlen   = bst_len;
  assign m_axi_arlen   = bst_len;
  assign m_axi_awsize  = 3'(LB);
  assign m_axi_arsize  = 3'(LB);
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = wr_strb;
  assign rd_data       = m_axi_rdata;

  always_comb begin
    state_nx      = state;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    wr_ready      = 1'b0;
    rd_valid      = 1'b0;
    rd_last       = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_bready  = 1'b0;
    cmd_done      = 1'b0;
    cmd_err       = 1'b0;
    bad_resp      = 1'b0;
    calc_load     = 1'b0;
    calc_addr     = nxt_addr;
    calc_rem      = nxt_rem;
    case (state)
      IDLE: begin
        // Gated by reset so cmd_ready reads 0 while reset is held.
        cmd_ready = init_calib_complete & ~ui_clk_sync_rst;
        if (cmd_valid && cmd_ready) begin
          calc_load = 1'b1;
          calc_addr = cmd_addr & ALIGN_MASK;
          calc_rem  = cmd_beats;
          state_nx  = (cmd_beats == '0) ? DONE : ADDR;
        end
      end
      ADDR: begin
        m_axi_awvalid = is_write;
        m_axi_arvalid = ~is_write;
        if (is_write ? m_axi_awready : m_axi_arready) state_nx = DATA;
      end
      DATA: begin
        if (is_write) begin
          m_axi_wvalid = wr_valid;
          wr_ready     = m_axi_wready;
          m_axi_wlast  = (beat_cnt == bst_len);
          if (wr_valid && m_axi_wready && m_axi_wlast) state_nx = RESP;
        end else begin
          rd_valid     = m_axi_rvalid;
          m_axi_rready = rd_ready;
          rd_last      = m_axi_rlast && (nxt_rem == '0);
          if (m_axi_rvalid && rd_ready) begin
            bad_resp = (m_axi_rresp != RESP_OKAY);
            if (m_axi_rlast) begin
              calc_load = (nxt_rem != '0);
              state_nx  = (nxt_rem == '0) ? DONE : ADDR;
            end
          end
        end
      end
      RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          bad_resp  = (m_axi_bresp != RESP_OKAY);
          calc_load = (nxt_rem != '0);
          state_nx  = (nxt_rem == '0) ? DONE : ADDR;
        end
      end
      DONE: begin
        cmd_done = 1'b1;
        cmd_err  = err_sticky;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state      <= IDLE;
      is_write   <= 1'b0;
      err_sticky <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cmd_valid && cmd_ready) begin
        is_write   <= cmd_write;
        err_sticky <= 1'b0;
      end else if (bad_resp) begin
        err_sticky <= 1'b1;
      end
      if (state == ADDR)                              beat_cnt <= '0;
      else if (m_axi_wvalid && m_axi_wready)          beat_cnt <= beat_cnt + 8'd1;
    end
  end

`ifdef MIG_PORT_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst)                       err_cnt_q <= '0;
    else if (bad_resp && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
  end
  assign err_count = err_cnt_q;
`else
  assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_mig_axi_port.sv
// Bench for mig_axi_port with default parameters (32 B/beat, 16-beat bursts).
module tb_mig_axi_port;

  localparam int AW = 28, DW = 256, IW = 4, BW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, calib = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [BW-1:0] cmd_beats = '0;
  logic wr_valid = 1'b1, wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic [DW/8-1:0] wr_strb = '1;
  logic rd_valid, rd_ready = 1'b0, rd_last, cmd_done, cmd_err;
  logic [DW-1:0] rd_data;
  logic [15:0] err_count;
  logic [IW-1:0] awid, arid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst;
  logic awvalid, awready = 1'b1, wlast, wvalid, wready = 1'b1, bready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0] bresp = 2'b00, rresp = 2'b00;
  logic bvalid = 1'b0, arvalid, arready = 1'b1, rlast = 1'b0, rvalid = 1'b0, rready;
  logic [DW-1:0] rdata = '0;

  mig_axi_port dut (
    .ui_clk(clk), .ui_clk_sync_rst(rst), .init_calib_complete(calib),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .cmd_done(cmd_done), .cmd_err(cmd_err), .err_count(err_count),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid('0), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rid('0), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
    .m_axi_rready(rready)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] wpat(input int i);
    return {(DW/32){32'hA500_0000 + 32'(i)}};
  endfunction
  function automatic logic [DW-1:0] rpat(input logic [AW-1:0] a);
    return {(DW/32){32'h5A00_0000 ^ 32'(a)}};
  endfunction

  // ---------------- slave / user-side driver ----------------
  int w_idx = 0, b_num = 0, b_err_idx = -1, r_beat = 0;
  logic [AW-1:0] arq_addr[$];
  logic [7:0]    arq_len[$];

  initial begin : bfm
    bit s_w, s_wl, s_b, s_ar, s_r;
    logic [AW-1:0] s_aa;
    logic [7:0] s_al;
    int cyc = 0;
    forever begin
      @(negedge clk);
      s_w = wvalid && wready; s_wl = wlast; s_b = bvalid && bready;
      s_ar = arvalid && arready; s_aa = araddr; s_al = arlen;
      s_r = rvalid && rready;
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
        bvalid = 0; rvalid = 0; rlast = 0; r_beat = 0;
        arq_addr.delete(); arq_len.delete();
        continue;
      end
      arready  = cyc[0];
      awready  = (cyc % 4) != 1;
      wready   = (cyc % 3) != 0;
      rd_ready = ~rd_ready;
      if (s_w) w_idx++;
      wr_data = wpat(w_idx);
      if (s_b) begin bvalid = 0; b_num++; end
      if (s_w && s_wl) begin
        bvalid = 1;
        bresp  = (b_num == b_err_idx) ? 2'b10 : 2'b00;
      end
      if (s_ar) begin arq_addr.push_back(s_aa); arq_len.push_back(s_al); end
      if (s_r) begin
        if (r_beat == int'(arq_len[0])) begin
          void'(arq_addr.pop_front()); void'(arq_len.pop_front()); r_beat = 0;
        end else r_beat++;
      end
      if (arq_addr.size() > 0) begin
        rvalid = 1;
        rdata  = rpat(arq_addr[0] + AW'(r_beat * 32));
        rlast  = (r_beat == int'(arq_len[0]));
      end else begin
        rvalid = 0; rlast = 0;
      end
    end
  end

  // ---------------- model + compare ----------------
  logic [AW+7:0] exp_aw[$], exp_ar[$], aw_log[$], ar_log[$];
  bit            exp_w[$];
  logic [AW:0]   exp_rd[$];
  int  done_cnt = 0, w_seen = 0, wlast_cnt = 0, rd_cnt = 0, rdlast_cnt = 0;
  int  b_left = 0, m_errcnt = 0;
  bit  pending = 0, m_err = 0, last_err = 0, chk_acc = 0, chk_done = 0, acc_wr = 0;
  int  acc_beats = 0;

  // Expected burst plan from first principles: each burst is as long as
  // the remaining count, 16 beats, and the room left in the 4 KB page allow.
  task automatic plan(input bit wr, input logic [AW-1:0] addr, input int beats);
    logic [AW-1:0] a;
    int rem, n, room;
    a = addr & ~AW'(31);
    rem = beats;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 32;
      n = (rem < 16) ? rem : 16;
      if (room < n) n = room;
      if (wr) begin
        exp_aw.push_back({a, 8'(n - 1)});
        b_left++;
        for (int k = 0; k < n; k++) exp_w.push_back(k == n - 1);
      end else begin
        exp_ar.push_back({a, 8'(n - 1)});
        for (int k = 0; k < n; k++)
          exp_rd.push_back({(k == n - 1) && (rem == n), a + AW'(k * 32)});
      end
      a = a + AW'(n * 32);
      rem -= n;
    end
  endtask

  initial begin : compare
    logic [AW+7:0] e;
    logic [AW:0] r;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_aw.delete(); exp_ar.delete(); exp_w.delete(); exp_rd.delete();
        pending = 0; chk_acc = 0; chk_done = 0; b_left = 0;
        continue;
      end
      if (chk_acc) begin
        chk_acc = 0;
        if (acc_beats == 0) begin
          chk("zero_beat_done_latency", cmd_done, 1);
          chk("zero_beat_no_axi", awvalid | arvalid, 0);
        end else if (acc_wr) chk("accept_to_awvalid", awvalid, 1);
        else                 chk("accept_to_arvalid", arvalid, 1);
      end
      if (chk_done) begin
        chk_done = 0;
        chk("final_to_done", cmd_done, 1);
      end
      if (cmd_done) begin
        done_cnt++;
        chk("done_was_expected", pending, 1);
        chk("cmd_err", cmd_err, m_err);
        last_err = cmd_err;
        pending = 0;
      end
      if (awvalid && awready) begin
        aw_log.push_back({awaddr, awlen});
        chk("aw_expected", exp_aw.size() != 0, 1);
        if (exp_aw.size() != 0) begin
          e = exp_aw.pop_front();
          chk("aw_addr", awaddr, e[AW+7:8]);
          chk("aw_len", awlen, e[7:0]);
        end
        chk("aw_size", awsize, 5);
        chk("aw_burst", awburst, 1);
      end
      if (arvalid && arready) begin
        ar_log.push_back({araddr, arlen});
        chk("ar_expected", exp_ar.size() != 0, 1);
        if (exp_ar.size() != 0) begin
          e = exp_ar.pop_front();
          chk("ar_addr", araddr, e[AW+7:8]);
          chk("ar_len", arlen, e[7:0]);
        end
      end
      if (wvalid && wready) begin
        chk("w_expected", exp_w.size() != 0, 1);
        if (exp_w.size() != 0) chk("w_last", wlast, exp_w.pop_front());
        chk("w_data", wdata, wpat(w_seen));
        chk("w_strb", wstrb, {(DW/8){1'b1}});
        w_seen++;
        if (wlast) wlast_cnt++;
      end
      if (bvalid && bready) begin
        if (bresp != 2'b00) begin m_err = 1; m_errcnt++; end
        b_left--;
        if (b_left == 0) chk_done = 1;
      end
      if (rd_valid && rd_ready) begin
        rd_cnt++;
        if (rd_last) rdlast_cnt++;
        chk("rd_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) begin
          r = exp_rd.pop_front();
          chk("rd_data", rd_data, rpat(r[AW-1:0]));
          chk("rd_last", rd_last, r[AW]);
          if (r[AW]) chk_done = 1;
        end
        if (rresp != 2'b00) begin m_err = 1; m_errcnt++; end
      end
      if (cmd_valid && cmd_ready) begin
        plan(cmd_write, cmd_addr, int'(cmd_beats));
        pending = 1; m_err = 0;
        chk_acc = 1; acc_wr = cmd_write; acc_beats = int'(cmd_beats);
      end
    end
  end

  // ---------------- directed tests ----------------
  task automatic issue(input bit wr, input logic [AW-1:0] a, input int beats);
    int t;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_beats = BW'(beats);
    t = 0;
    do begin @(negedge clk); t++; end while (!cmd_ready && t < 500);
    chk("cmd_accept_timeout", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 3000) begin @(negedge clk); t++; end
    chk("done_count", done_cnt, target);
    repeat (2) @(negedge clk);
    chk("no_leftover_aw", exp_aw.size() + exp_ar.size() + exp_w.size() + exp_rd.size(), 0);
  endtask

  task automatic run(input bit wr, input logic [AW-1:0] a, input int beats);
    int d = done_cnt;
    aw_log.delete(); ar_log.delete();
    wlast_cnt = 0; rd_cnt = 0; rdlast_cnt = 0;
    issue(wr, a, beats);
    wait_done(d + 1);
  endtask

  initial begin : main
    int d, t, ws;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_valids", {awvalid, arvalid, wvalid, rd_valid}, 0);
    chk("rst_readys", {wr_ready, rready, bready}, 0);
    chk("rst_done_err_last", {cmd_done, cmd_err, rd_last}, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_addr_len", {awaddr, awlen}, 0);
    @(posedge clk); #2; rst = 0;

    // 40-beat write from 0
    run(1, 28'h0000, 40);
    chk("t1_aw_count", aw_log.size(), 3);
    if (aw_log.size() == 3) begin
      chk("t1_aw0", aw_log[0], {28'h0000, 8'd15});
      chk("t1_aw1", aw_log[1], {28'h0200, 8'd15});
      chk("t1_aw2", aw_log[2], {28'h0400, 8'd7});
    end
    chk("t1_wlast_count", wlast_cnt, 3);
    chk("t1_err", last_err, 0);

    // 4 KB boundary split
    run(1, 28'h0FE0, 4);
    chk("t2_aw_count", aw_log.size(), 2);
    if (aw_log.size() == 2) begin
      chk("t2_aw0", aw_log[0], {28'h0FE0, 8'd0});
      chk("t2_aw1", aw_log[1], {28'h1000, 8'd2});
    end

    // 20-beat read with rd_ready toggling
    run(0, 28'h2000, 20);
    chk("t3_ar_count", ar_log.size(), 2);
    if (ar_log.size() == 2) begin
      chk("t3_ar0", ar_log[0], {28'h2000, 8'd15});
      chk("t3_ar1", ar_log[1], {28'h2200, 8'd3});
    end
    chk("t3_rd_beats", rd_cnt, 20);
    chk("t3_rd_last_count", rdlast_cnt, 1);

    // zero beats, unaligned address (low bits ignored)
    run(1, 28'h3007, 0);
    chk("t4_no_axi", aw_log.size() + ar_log.size(), 0);

    // SLVERR on second B of a three-burst write
    b_err_idx = b_num + 1;
    run(1, 28'h3000, 40);
    chk("t5_aw_count", aw_log.size(), 3);
    chk("t5_cmd_err", last_err, 1);
`ifdef MIG_PORT_ERR_CNT_EN
    chk("t5_err_count", err_count, 1);
`else
    chk("t5_err_count", err_count, 0);
`endif
    b_err_idx = -1;
    run(1, 28'h4000, 2);
    chk("t5b_err_cleared", last_err, 0);

    // calibration low holds commands
    d = done_cnt;
    calib = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 28'h0100; cmd_beats = 3;
    repeat (5) begin
      @(negedge clk);
      chk("calib_low_cmd_ready", cmd_ready, 0);
      chk("calib_low_no_ar", arvalid, 0);
    end
    @(posedge clk); #1; calib = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!cmd_ready && t < 50);
    @(posedge clk); #1; cmd_valid = 0;
    wait_done(d + 1);

    // reset in the middle of a write data phase
    d = done_cnt;
    ws = w_seen;
    issue(1, 28'h0000, 40);
    t = 0;
    while (w_seen < ws + 5 && t < 500) begin @(negedge clk); t++; end
    chk("t7_reached_data", w_seen >= ws + 5, 1);
    @(posedge clk); #2; rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("t7_valids_after_rst", {awvalid, arvalid, wvalid, rd_valid}, 0);
    chk("t7_readys_after_rst", {cmd_ready, wr_ready, rready, bready}, 0);
    chk("t7_no_done", cmd_done, 0);
    @(posedge clk); #2; rst = 0;
    repeat (6) @(negedge clk);
    chk("t7_no_done_count", done_cnt, d);
    chk("t7_err_count_cleared", err_count, 0);
    run(0, 28'h0FFFFFE0, 3);  // address wraps modulo 2^28
    chk("t8_ar_count", ar_log.size(), 2);
    chk("t8_rd_beats", rd_cnt, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
